// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency MULT/MULTU/DIV/DIVU with HI/LO ownership.
// Optional build macro MDU_DIV0_FLAG_EN adds the one-cycle div0 commit flag output.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic        div0
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DIV_BUSY = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_div0_q, pend_div0_d;

    // Datapath: both products and the division are resolved at the start edge.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;

    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Magnitude division avoids the signed overflow corner (0x80000000 / -1).
    assign div_signed = (md_op == OP_DIV);
    assign a_neg      = div_signed & a[31];
    assign b_neg      = div_signed & b[31];
    assign a_mag      = a_neg ? (~a + 32'd1) : a;
    assign b_mag      = b_neg ? (~b + 32'd1) : b;
    assign divisor    = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

`ifdef MDU_DIV0_FLAG_EN
    logic div0_q, div0_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
`ifdef MDU_DIV0_FLAG_EN
        div0_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = (md_op == OP_MULT) ? prod_s : prod_u;
                            pend_div0_d = 1'b0;
                            cnt_d       = MUL_CNT;
                            busy_d      = 1'b1;
                            state_d     = S_MUL_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d   = rem;
                            pend_lo_d   = quot;
                            pend_div0_d = (b == 32'd0);
                            cnt_d       = DIV_CNT;
                            busy_d      = 1'b1;
                            state_d     = S_DIV_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL_BUSY, S_DIV_BUSY: begin
                // Requests arriving here are protocol violations and are dropped.
                if (cnt_q == CNT_ONE) begin
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
`ifdef MDU_DIV0_FLAG_EN
                    div0_d      = pend_div0_q;
`endif
                    pend_div0_d = 1'b0;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_div0_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= div0_d;
        end
    end

    assign div0 = div0_q;
`endif

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
